// File: rtl/latch_bank_write_arbiter.sv
// latch_bank_write_arbiter
// ------------------------
// Round-robin write controller for a bank of D-latch storage cells. It picks
// one requester at a time and drives the selected cell's latch enable through
// a SETUP / OPEN / HOLD pattern. The data bus is therefore stable for one full
// cycle before the enable rises and for one full cycle after it falls.
//
// Ports
//   clk        system clock, rising edge
//   reset      asynchronous, active-high
//   req        per-requester write request (level)
//   req_addr   per-requester target cell, requester i at [i*ADDR_W +: ADDR_W]
//   req_data   per-requester write data, requester i at [i*WIDTH +: WIDTH]
//   gnt        one-hot grant, high from SETUP through HOLD
//   ack        one-hot, one-cycle completion pulse in HOLD
//   err        one-cycle pulse in HOLD when the captured address >= DEPTH
//   busy       high whenever the FSM is not IDLE
//   latch_en   one-hot latch enable, only ever high in OPEN
//   latch_d    data bus shared by all latch cells
//   dbg_state  current FSM state (IDLE=0, SETUP=1, OPEN=2, HOLD=3)
//
// Handshake: a requester holds req high (level) until it sees its ack bit pulse.
// The request is sampled and its addr/data are captured only while IDLE. After
// capture, req, req_addr and req_data may change freely without effect on the
// write in flight. A req still high after ack counts as a new request.
//
// Every output is decoded from asynchronously reset registers. A reset pulse
// therefore clears the enables immediately, including in the middle of OPEN.

module latch_bank_write_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 8,
  parameter int DEPTH   = 4,
  parameter int ADDR_W  = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*WIDTH-1:0]  req_data,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        ack,
  output logic                      err,
  output logic                      busy,
  output logic [DEPTH-1:0]          latch_en,
  output logic [WIDTH-1:0]          latch_d,
  output logic [1:0]                dbg_state
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    OPEN  = 2'd2,
    HOLD  = 2'd3
  } state_t;

  state_t             state_q,   state_d;
  logic [PTR_W-1:0]   rr_ptr_q,  rr_ptr_d;
  logic [PTR_W-1:0]   gnt_idx_q, gnt_idx_d;
  logic [ADDR_W-1:0]  addr_q,    addr_d;
  logic [WIDTH-1:0]   data_q,    data_d;

  logic               win_found;
  logic [PTR_W-1:0]   win_idx;
  int                 idx;

  // Round-robin search: the first requesting index at or after rr_ptr_q,
  // wrapping modulo NUM_REQ.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    idx       = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(rr_ptr_q) + k) % NUM_REQ;
      if (!win_found && req[idx]) begin
        win_found = 1'b1;
        win_idx   = PTR_W'(idx);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      rr_ptr_q  <= '0;
      gnt_idx_q <= '0;
      addr_q    <= '0;
      data_q    <= '0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      gnt_idx_q <= gnt_idx_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    gnt_idx_d = gnt_idx_q;
    addr_d    = addr_q;
    data_d    = data_q;
    case (state_q)
      IDLE: begin
        if (win_found) begin
          state_d   = SETUP;
          gnt_idx_d = win_idx;
          addr_d    = req_addr[win_idx*ADDR_W +: ADDR_W];
          data_d    = req_data[win_idx*WIDTH +: WIDTH];
        end
      end
      SETUP: state_d = OPEN;
      OPEN:  state_d = HOLD;
      HOLD: begin
        state_d  = IDLE;
        rr_ptr_d = (gnt_idx_q == PTR_W'(NUM_REQ - 1)) ? '0 : gnt_idx_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output decode. latch_d is the captured data register itself, so it keeps
  // the last written value while IDLE.
  always_comb begin
    gnt       = '0;
    ack       = '0;
    err       = 1'b0;
    busy      = (state_q != IDLE);
    latch_en  = '0;
    latch_d   = data_q;
    dbg_state = state_q;
    if (state_q != IDLE) begin
      gnt[gnt_idx_q] = 1'b1;
    end
    if (state_q == OPEN && int'(addr_q) < DEPTH) begin
      latch_en[addr_q] = 1'b1;
    end
    if (state_q == HOLD) begin
      ack[gnt_idx_q] = 1'b1;
      err            = (int'(addr_q) >= DEPTH);
    end
  end

endmodule

// File: tb/tb_latch_bank_write_arbiter.sv
// Bench for latch_bank_write_arbiter. Two instances share one set of inputs:
// u_a with DEPTH=4 (every address is valid) and u_b with DEPTH=3 (address 3 is
// out of range). A transaction-level reference model tracks the write in
// flight and its age in cycles. The outputs of both instances are checked
// against that model after every rising edge.

module tb_latch_bank_write_arbiter;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int AW = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [N-1:0]    req;
  logic [N*AW-1:0] req_addr;
  logic [N*W-1:0]  req_data;

  logic [N-1:0] a_gnt, a_ack, b_gnt, b_ack;
  logic         a_err, a_busy, b_err, b_busy;
  logic [3:0]   a_en;
  logic [2:0]   b_en;
  logic [W-1:0] a_d, b_d;
  logic [1:0]   a_st, b_st;

  latch_bank_write_arbiter #(.NUM_REQ(N), .WIDTH(W), .DEPTH(4), .ADDR_W(AW)) u_a (
    .clk(clk), .reset(reset), .req(req), .req_addr(req_addr), .req_data(req_data),
    .gnt(a_gnt), .ack(a_ack), .err(a_err), .busy(a_busy),
    .latch_en(a_en), .latch_d(a_d), .dbg_state(a_st)
  );

  latch_bank_write_arbiter #(.NUM_REQ(N), .WIDTH(W), .DEPTH(3), .ADDR_W(AW)) u_b (
    .clk(clk), .reset(reset), .req(req), .req_addr(req_addr), .req_data(req_data),
    .gnt(b_gnt), .ack(b_ack), .err(b_err), .busy(b_busy),
    .latch_en(b_en), .latch_d(b_d), .dbg_state(b_st)
  );

  // ---------------- scoreboard state ----------------
  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];   // {who, data} of each granted write, in grant order
  int ack_order[$];

  // Reference model: one write in flight at most, with its age in cycles
  // since the grant edge (0 = SETUP, 1 = OPEN, 2 = HOLD).
  bit           m_busy;
  int           m_age, m_who, m_addr, m_rr;
  logic [W-1:0] m_data, m_ld;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_age = 0; m_who = 0; m_addr = 0; m_rr = 0;
    m_data = '0; m_ld = '0;
    exp_q.delete();
  endtask

  task automatic model_edge();
    if (reset) begin
      model_reset();
      return;
    end
    if (m_busy) begin
      m_age++;
      if (m_age == 3) begin
        m_busy = 0;
        m_rr   = (m_who + 1) % N;
      end
    end else if (req != '0) begin
      for (int k = 0; k < N; k++) begin
        if (req[(m_rr + k) % N]) begin
          m_who = (m_rr + k) % N;
          break;
        end
      end
      m_addr = int'(req_addr[m_who*AW +: AW]);
      m_data = req_data[m_who*W +: W];
      m_ld   = m_data;
      m_busy = 1;
      m_age  = 0;
      exp_q.push_back((32'(m_who) << 8) | 32'(m_data));
    end
  endtask

  task automatic check_outputs();
    logic [N-1:0] e_gnt, e_ack;
    logic [3:0]   e_en_a;
    logic [2:0]   e_en_b;
    logic [31:0]  e;
    logic [1:0]   e_st;
    bit           in_hold;
    e_gnt = '0; e_ack = '0; e_en_a = '0; e_en_b = '0;
    in_hold = m_busy && (m_age == 2);
    e_st = m_busy ? 2'(m_age + 1) : 2'd0;
    if (m_busy) e_gnt[m_who] = 1'b1;
    if (in_hold) e_ack[m_who] = 1'b1;
    if (m_busy && m_age == 1) begin
      e_en_a[m_addr] = 1'b1;
      if (m_addr < 3) e_en_b[m_addr] = 1'b1;
    end
    check_eq("a_gnt", 32'(a_gnt), 32'(e_gnt));
    check_eq("a_ack", 32'(a_ack), 32'(e_ack));
    check_eq("a_err", 32'(a_err), 32'd0);
    check_eq("a_busy", 32'(a_busy), 32'(m_busy));
    check_eq("a_latch_en", 32'(a_en), 32'(e_en_a));
    check_eq("a_latch_d", 32'(a_d), 32'(m_ld));
    check_eq("a_state", 32'(a_st), 32'(e_st));
    check_eq("b_gnt", 32'(b_gnt), 32'(e_gnt));
    check_eq("b_ack", 32'(b_ack), 32'(e_ack));
    check_eq("b_err", 32'(b_err), 32'(in_hold && m_addr >= 3));
    check_eq("b_busy", 32'(b_busy), 32'(m_busy));
    check_eq("b_latch_en", 32'(b_en), 32'(e_en_b));
    check_eq("b_latch_d", 32'(b_d), 32'(m_ld));
    if (a_ack != '0) begin
      if (exp_q.size() == 0) begin
        check_eq("sb_unexpected_ack", 32'(a_ack), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check_eq("sb_ack_who", 32'(a_ack), 32'd1 << e[15:8]);
        check_eq("sb_ack_data", 32'(a_d), 32'(e[7:0]));
      end
      for (int i = 0; i < N; i++) if (a_ack[i]) ack_order.push_back(i);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    model_edge();
    #1 check_outputs();
    @(negedge clk);
  endtask

  task automatic set_req(input int who, input int addr, input logic [W-1:0] data);
    req_addr[who*AW +: AW] = AW'(addr);
    req_data[who*W +: W]   = data;
  endtask

  task automatic sync_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic wait_ack(input int budget);
    for (int c = 0; c < budget; c++) begin
      step();
      if (a_ack != '0) return;
    end
    check_eq("ack_timeout", 32'd1, 32'd0);
  endtask

  // ---------------- main sequence ----------------
  int rr_exp[5] = '{0, 1, 2, 3, 0};

  initial begin
    req = '0; req_addr = '0; req_data = '0;
    reset = 1'b0;
    model_reset();
    #1 reset = 1'b1;
    #1 check_outputs();
    step();
    step();
    reset = 1'b0;

    // single write: requester 1 -> cell 3, data A5
    set_req(1, 3, 8'hA5);
    req = 4'b0010;
    wait_ack(8);
    check_eq("single_ack", 32'(a_ack), 32'h2);
    req = '0;
    step();
    check_eq("single_busy_after", 32'(a_busy), 32'd0);
    step();

    // round robin from rr_ptr = 0 with every requester asserting
    sync_reset();
    for (int i = 0; i < N; i++) set_req(i, $urandom_range(0, 3), W'($urandom));
    ack_order.delete();
    req = 4'b1111;
    for (int i = 0; i < 5; i++) wait_ack(8);
    req = '0;
    check_eq("rr_count", 32'(ack_order.size()), 32'd5);
    for (int i = 0; i < 5 && i < ack_order.size(); i++)
      check_eq("rr_order", 32'(ack_order[i]), 32'(rr_exp[i]));
    step(); step();

    // wrap-around: grant requester 2, then 3 must beat 0
    sync_reset();
    set_req(2, 1, 8'h11); set_req(3, 2, 8'h33); set_req(0, 0, 8'h00);
    req = 4'b0100;
    wait_ack(8);
    ack_order.delete();
    req = 4'b1001;
    wait_ack(8);
    wait_ack(8);
    req = '0;
    check_eq("wrap_count", 32'(ack_order.size()), 32'd2);
    if (ack_order.size() == 2) begin
      check_eq("wrap_first", 32'(ack_order[0]), 32'd3);
      check_eq("wrap_second", 32'(ack_order[1]), 32'd0);
    end
    step(); step();

    // out-of-range on u_b: address 3 with DEPTH=3
    set_req(0, 3, 8'h3C);
    req = 4'b0001;
    wait_ack(8);
    check_eq("oor_err_b", 32'(b_err), 32'd1);
    check_eq("oor_ack_b", 32'(b_ack), 32'd1);
    check_eq("oor_en_b", 32'(b_en), 32'd0);
    req = '0;
    step(); step();

    // mid-transaction changes: drop req and scribble data during OPEN
    set_req(0, 2, 8'h5A);
    req = 4'b0001;
    step();
    step();
    check_eq("mid_open_en", 32'(a_en), 32'h4);
    req = '0;
    req_data = '1;
    step();
    check_eq("mid_ack", 32'(a_ack), 32'h1);
    check_eq("mid_latch_d", 32'(a_d), 32'h5A);
    step();
    step();
    check_eq("mid_no_regrant", 32'(a_busy), 32'd0);

    // asynchronous reset while OPEN with latch_en[2] high
    set_req(1, 2, 8'hC3);
    req = 4'b0010;
    step();
    step();
    check_eq("arst_pre_en", 32'(a_en), 32'h4);
    req = '0;
    #2 reset = 1'b1;
    #1;
    model_reset();
    check_eq("arst_en", 32'(a_en), 32'd0);
    check_eq("arst_gnt", 32'(a_gnt), 32'd0);
    check_eq("arst_busy", 32'(a_busy), 32'd0);
    check_outputs();
    @(negedge clk);
    step();
    reset = 1'b0;
    repeat (3) step();

    // randomized traffic
    for (int c = 0; c < 400; c++) begin
      req = N'($urandom_range(0, (1 << N) - 1));
      if ($urandom_range(0, 3) == 0) req = '0;
      req_addr = ($urandom);
      req_data = ($urandom);
      step();
    end
    req = '0;
    repeat (5) step();
    check_eq("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired got=running exp=finished");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/latch_bank_write_arbiter.md
# latch_bank_write_arbiter

Round-robin write controller that shares a bank of D-latch storage cells (each cell is a D latch built on the team's SR latch) between several requesters. It accepts write requests, picks one at a time, and sequences the selected cell's latch enable through a setup/open/hold pattern. This ensures latch data is stable before the enable rises and after it falls. It sits between the requesting logic and the latch bank and is the only driver of the bank's enable and data lines.

## Interface
Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- WIDTH, 8, data width of each latch cell
- DEPTH, 4, number of latch cells in the bank
- ADDR_W, 2, cell address width; must satisfy 2**ADDR_W >= DEPTH

Ports:
- clk  in  1  system clock; all state changes on the rising edge
- reset  in  1  asynchronous, active-high; one clock domain
- req  in  NUM_REQ  per-requester write request, level
- req_addr  in  NUM_REQ*ADDR_W  target cell per requester; requester i uses bits [i*ADDR_W +: ADDR_W]
- req_data  in  NUM_REQ*WIDTH  write data per requester; requester i uses bits [i*WIDTH +: WIDTH]
- gnt  out  NUM_REQ  one-hot; high for the granted requester from SETUP through HOLD
- ack  out  NUM_REQ  one-hot, one-cycle pulse in HOLD; marks write complete
- err  out  1  one-cycle pulse in HOLD when the captured address is >= DEPTH
- busy  out  1  high whenever state != IDLE
- latch_en  out  DEPTH  one-hot enable to the latch cells; high only in OPEN
- latch_d  out  WIDTH  data bus to all latch cells

## Operation
- FSM states: IDLE, SETUP, OPEN, HOLD.
- IDLE:
  - If any req bit is high, grant the first requester at or after rr_ptr, searching upward and wrapping modulo NUM_REQ.
  - Capture that requester's addr and data into internal registers.
  - Go to SETUP.
  - Otherwise remain in IDLE.
- SETUP: gnt high; latch_d drives captured data; latch_en all 0; go to OPEN.
- OPEN:
  - gnt high; latch_d unchanged.
  - latch_en[addr] = 1 if addr < DEPTH, else all 0.
  - Go to HOLD.
- HOLD:
  - latch_en all 0; latch_d unchanged; gnt high.
  - ack[granted] = 1; err = 1 if addr >= DEPTH.
  - rr_ptr <= (granted + 1) mod NUM_REQ; go to IDLE.
- Capture rules:
  - Data and addr are captured once, in IDLE.
  - Changes on req_addr or req_data after capture have no effect.
  - Deasserting req mid-transaction does not abort it; ack still pulses.
- Arbitration happens only in IDLE.
- A requester still asserting req after its ack is treated as a new request, competing under the advanced rr_ptr.
- latch_d holds its last value in IDLE; it is not cleared between writes.
- Out-of-range write: full 4-state sequence runs, no cell is enabled, and err pulses alongside ack.

## Timing
- Reset values: state IDLE, rr_ptr 0, gnt 0, ack 0, err 0, busy 0, latch_en 0, latch_d 0, captured addr/data 0.
- Reset asserted in any state forces all of the above immediately, without waiting for a clock edge. A cell in OPEN therefore sees its enable drop asynchronously, and it keeps whatever value it had latched.
- First arbitration occurs on the first rising edge after reset deassertion.
- Write latency:
  - req sampled high at edge N while in IDLE.
  - SETUP during cycle N..N+1.
  - OPEN during N+1..N+2, with latch_en high exactly one cycle.
  - HOLD during N+2..N+3, with the ack pulse.
  - Back in IDLE after edge N+3.
- Throughput: one write per 4 cycles, because HOLD always returns to IDLE.
- Timing invariants:
  - latch_d is stable at least one cycle before and one cycle after latch_en is high.
  - latch_en and ack are never high in the same cycle.
  - At most one latch_en bit is ever high.

## Test plan
- Reset check: assert reset mid-sequence with latch_en[2]=1 in OPEN -> latch_en, gnt and busy go to 0 without a clock edge. After release with req=0, all outputs stay 0.
- Single write: req=4'b0010, addr1=3, data1=8'hA5 -> gnt=0010 for 3 cycles; latch_d=A5 from SETUP; latch_en=1000 for exactly one cycle; ack=0010 pulses in HOLD; busy=0 on the next cycle.
- Round-robin: req=4'b1111 held continuously -> grant order 0,1,2,3,0, with ack pulses 4 cycles apart.
- Wrap-around: rr_ptr=3 after a grant to requester 2; req=4'b1001 -> requester 3 is granted first, then requester 0.
- Out of range with DEPTH=3, ADDR_W=2: write to addr 3 -> latch_en stays 0 throughout; ack and err pulse together in HOLD.
- Mid-transaction changes: drop req and change req_data during OPEN -> latch_d keeps the captured value; ack still pulses; no new grant follows.
